sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
// - Off-chip SRAM controller directly downstream of the memory stage; replaces on-chip data memory.
// - Splits each 32-bit word access into two 16-bit SRAM accesses with programmable wait states.
// - Drives ready low (pipeline freeze) while busy; the memory stage holds its request stable until ready=1.
// PARAMETERS
// - BASE_ADDR   1024  byte address mapped to SRAM word 0
// - WAIT_CYCLES 1     extra cycles per 16-bit phase; phase length = WAIT_CYCLES+1
// - SRAM_AW     18    SRAM half-word address width
// PORTS
// - clk          in   1        single clock, rising edge
// - rst          in   1        synchronous, active-high reset
// - mem_read     in   1        read request, level, held until ready
// - mem_write    in   1        write request, level, held until ready
// - address      in   32       byte address from ALU result
// - wdata        in   32       store data (val_Rm)
// - rdata        out  32       load data, valid in the cycle ready=1 completes a read
// - ready        out  1        0 = freeze all pipeline registers
// - sram_addr    out  SRAM_AW  half-word address
// - sram_dq_out  out  16       write data to pad
// - sram_dq_oe   out  1        pad output enable (top level builds the tristate)
// - sram_dq_in   in   16       read data from pad
// - sram_we_n    out  1        write enable, active low
// - sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1  tied 0 (always selected, both bytes)
// BEHAVIOUR
// - Reset: state IDLE, ready=1 when no request, rdata=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0.
// - word = (address-BASE_ADDR)>>2, truncated to SRAM_AW-1 bits; low half at {word,0}, high at {word,1}.
// - States: IDLE -> LOW -> HIGH -> DONE -> IDLE. LOW/HIGH each last WAIT_CYCLES+1 cycles (phase counter).
// - IDLE: ready = !(mem_read|mem_write) (combinational); on request, latch address/wdata/op, go LOW.
// - LOW/HIGH: ready=0. Write: sram_we_n=0 and dq_oe=1 every cycle of phase, dq_out=wdata half.
//   Read: we_n=1, dq_oe=0; sram_dq_in sampled on last cycle of phase into rdata[15:0] / rdata[31:16].
// - DONE: ready=1 for exactly one cycle; pipeline advances; next cycle IDLE re-evaluates request.
// - Latency: ready low for 2*(WAIT_CYCLES+1)+1 cycles per access; WAIT_CYCLES=1 -> ready=1 on 6th cycle.
// - mem_read and mem_write both high: write wins (illegal from decode; no error raised).
// - Request inputs ignored outside IDLE (latched copy used); deassertion mid-access does not abort.
// - rdata holds last read value until next read completes; writes do not alter it.
// - rst mid-access: immediate IDLE, we_n=1, dq_oe=0; partial SRAM write is not rolled back.
// CONFIGURATION
// - SRAM_POST_WRITE_EN defined: one-entry posted write. In IDLE, a write gives ready=1 the same cycle,
//   latches data and runs LOW/HIGH in background, skipping DONE. Any request arriving while busy sees
//   ready=0 until background write ends, then is served normally (read-after-write returns new data).
// - Undefined: writes block exactly like reads (full latency above).
// STRUCTURE
// - sram_ctrl_pkg: state enum (IDLE/LOW/HIGH/DONE), HALF_LO/HALF_HI select constants, BASE_ADDR default.
// - Sub-module sram_phase_timer: loadable down-counter, outputs phase_last; reset to 0.
// TESTING
// - Read, WAIT_CYCLES=1: addr=1024, dq_in 0x5678 then 0x1234 -> sram_addr 0 then 1, rdata=0x12345678, ready high cycle 6.
// - Write addr=1032 data=0xDEADBEEF -> addr 4 dq 0xBEEF we_n=0 x2, addr 5 dq 0xDEAD we_n=0 x2, ready cycle 6.
// - Back-to-back write 1024 then read 1024 with SRAM model -> rdata=written value, no idle gap beyond IDLE cycle.
// - rst asserted in HIGH of a write -> next cycle we_n=1, dq_oe=0, state IDLE, ready=1 with no request.
// - read&write both high, addr 1028 data 0x0000FFFF -> write performed to halves 2,3; rdata unchanged.
// - SRAM_POST_WRITE_EN: write then read -> write ready=1 cycle 0; read ready=0 until write done, then returns new data.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the off-chip SRAM controller.
// The posted-write option is selected with the SRAM_POST_WRITE_EN macro.
package sram_ctrl_pkg;

    // Access sequencer states: one IDLE decision cycle, two half-word phases,
    // and a single completion cycle that releases the pipeline.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // Half-word select appended below the word index to form the SRAM address.
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // Byte address that maps onto SRAM word 0.
    localparam int unsigned BASE_ADDR_DEF = 1024;

    // 32-bit word index of a byte address relative to the SRAM window.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter that times one SRAM half-word phase.
// phase_last_o is high while the count is zero, i.e. on the final cycle
// of a phase that was loaded with (phase length - 1).
module sram_phase_timer #(
    parameter int TW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          phase_last_o
);

    logic [TW-1:0] cnt_q, cnt_d;

    // Next count: reload at the start of a phase, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_last_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Off-chip SRAM controller: turns one 32-bit load/store from the memory
// stage into two 16-bit SRAM accesses (low half, then high half), each
// stretched to WAIT_CYCLES+1 cycles, and freezes the pipeline via ready.
// Optional SRAM_POST_WRITE_EN: stores are acknowledged immediately and
// complete in the background; any request arriving meanwhile is stalled.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          WAIT_CYCLES = 1,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int TW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int WW = SRAM_AW - 1;

    state_t        state_q, state_d;
    logic [WW-1:0] word_q, word_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [15:0]   lo_q, lo_d;
    logic          is_wr_q, is_wr_d;
    logic          tmr_load;
    logic          phase_last;
    logic          req;

    assign req = mem_read | mem_write;

    sram_phase_timer #(
        .TW (TW)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (tmr_load),
        .load_val_i   (TW'(WAIT_CYCLES)),
        .phase_last_o (phase_last)
    );

    // Sequencer next state, request latching, read assembly and ready.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        lo_d     = lo_q;
        is_wr_d  = is_wr_q;
        tmr_load = 1'b0;
        ready    = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef SRAM_POST_WRITE_EN
                // A store is accepted on the spot and finishes in the background.
                ready = mem_write ? 1'b1 : !req;
`else
                ready = !req;
`endif
                if (req) begin
                    word_d   = WW'(word_index(address, 32'(BASE_ADDR)));
                    wdata_d  = wdata;
                    is_wr_d  = mem_write;   // write wins if both are raised
                    tmr_load = 1'b1;
                    state_d  = LOW;
                end
            end
            LOW: begin
`ifdef SRAM_POST_WRITE_EN
                ready = is_wr_q ? !req : 1'b0;
`endif
                if (phase_last) begin
                    if (!is_wr_q) begin
                        lo_d = sram_dq_in;
                    end
                    tmr_load = 1'b1;
                    state_d  = HIGH;
                end
            end
            HIGH: begin
`ifdef SRAM_POST_WRITE_EN
                ready = is_wr_q ? !req : 1'b0;
`endif
                if (phase_last) begin
                    // rdata changes only once both halves are in hand.
                    if (!is_wr_q) begin
                        rdata_d = {sram_dq_in, lo_q};
                    end
`ifdef SRAM_POST_WRITE_EN
                    state_d = is_wr_q ? IDLE : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and latched-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            lo_q    <= '0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            lo_q    <= lo_d;
            is_wr_q <= is_wr_d;
        end
    end

    // SRAM pin drive: active only during the two half-word phases.
    always_comb begin
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;
        if (state_q == LOW || state_q == HIGH) begin
            sram_addr = {word_q, (state_q == HIGH) ? HALF_HI : HALF_LO};
            if (is_wr_q) begin
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
            end
        end
    end

    assign rdata     = rdata_q;
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: asynchronous SRAM pad model plus a
// half-word reference memory; directed cases followed by random traffic.
module tb_sram_ctrl;

    localparam int          SRAM_AW = 18;
    localparam int          WC      = 1;
    localparam int          PH      = WC + 1;
    localparam int unsigned BASE    = 1024;
    localparam int          WMASK   = (1 << (SRAM_AW - 1)) - 1;
    localparam int          LIMIT   = 40;
`ifdef SRAM_POST_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               mem_read;
    logic               mem_write;
    logic [31:0]        address;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_we_n;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_ub_n;
    logic               sram_lb_n;

    logic [15:0] sram_arr [0:1023];   // pad-side SRAM contents
    logic [15:0] ref_half [0:1023];   // what the SRAM should hold
    logic [31:0] last_rd;             // what rdata should show
    int          n_vec;
    int          n_err;

    sram_ctrl #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WC),
        .SRAM_AW     (SRAM_AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: reads are combinational, writes land on the clock edge.
    assign sram_dq_in = sram_arr[sram_addr[9:0]];
    always @(posedge clk) begin
        if (!sram_we_n) sram_arr[sram_addr[9:0]] <= sram_dq_out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pin invariants that hold on every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("dq_oe_vs_we_n", 32'(sram_dq_oe), 32'(!sram_we_n));
            chk("tied_selects", {28'd0, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'd0);
        end
    end

    // One memory-stage access held until ready; chk_lat asks for an exact latency.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit chk_lat);
        int          w;
        int          exp_lat;
        bit          got;
        bit          hi;
        logic [31:0] exp_rd;
        w      = int'(((addr - BASE) >> 2) & WMASK);
        exp_rd = {ref_half[2*w+1], ref_half[2*w]};
        exp_lat = (POSTED && wr) ? 0 : 2*PH + 1;
        if (wr) begin
            ref_half[2*w]   = data[15:0];
            ref_half[2*w+1] = data[31:16];
        end
        @(posedge clk); #1;
        mem_read  = rd;
        mem_write = wr;
        address   = addr;
        wdata     = data;
        got = 1'b0;
        for (int c = 0; c <= LIMIT && !got; c++) begin
            @(negedge clk);
`ifndef SRAM_POST_WRITE_EN
            if (c >= 1 && c <= 2*PH) begin
                hi = (c > PH);
                chk("sram_addr", 32'(sram_addr), 32'(2*w + (hi ? 1 : 0)));
                chk("sram_we_n", 32'(sram_we_n), 32'(!wr));
                if (wr) chk("sram_dq_out", 32'(sram_dq_out), hi ? 32'(data[31:16]) : 32'(data[15:0]));
            end else if (c <= 2*PH + 1) begin
                chk("we_n_idle", 32'(sram_we_n), 32'd1);
            end
`endif
            if (ready) begin
                got = 1'b1;
                if (chk_lat) chk("ready_cycle", 32'(c), 32'(exp_lat));
                if (!wr) last_rd = exp_rd;
                chk(wr ? "rdata_kept" : "rdata", rdata, last_rd);
            end
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
        $display("%s addr=0x%08h data=0x%08h rdata=0x%08h", wr ? "WR" : "RD", addr, data, rdata);
    endtask

    // Drop requests and let any background work drain; ready must read 1.
    task automatic go_idle();
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (2*PH + 3) @(posedge clk);
        @(negedge clk);
        chk("ready_idle", 32'(ready), 32'd1);
    endtask

    initial begin
        int          op;
        logic [31:0] a;
        n_vec = 0;
        n_err = 0;
        last_rd = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            sram_arr[i] <= 16'(i * 37 + 5);
            ref_half[i]  = 16'(i * 37 + 5);
        end
        sram_arr[0] <= 16'h5678;  ref_half[0] = 16'h5678;
        sram_arr[1] <= 16'h1234;  ref_half[1] = 16'h1234;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = '0; wdata = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Read of word 0 assembles 0x1234:0x5678.
        access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b1);
        chk("lit_read", rdata, 32'h12345678);
        go_idle();

        // Write to 1032 lands in halves 4 and 5.
        access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b1);
        go_idle();
        chk("lit_half4", 32'(sram_arr[4]), 32'h0000BEEF);
        chk("lit_half5", 32'(sram_arr[5]), 32'h0000DEAD);

        // Back-to-back write then read of the same word.
        access(1'b0, 1'b1, 32'd1024, 32'hA5A5C3C3, 1'b1);
        access(1'b1, 1'b0, 32'd1024, 32'd0, !POSTED);
        chk("lit_raw", rdata, 32'hA5A5C3C3);
        go_idle();

        // Read and write together: the write is performed, rdata untouched.
        access(1'b1, 1'b1, 32'd1028, 32'h0000FFFF, 1'b1);
        go_idle();
        chk("lit_both_lo", 32'(sram_arr[2]), 32'h0000FFFF);
        chk("lit_both_hi", 32'(sram_arr[3]), 32'h00000000);
        chk("lit_both_rdata", rdata, 32'hA5A5C3C3);

`ifndef SRAM_POST_WRITE_EN
        // Reset in the first HIGH cycle of a write.
        @(posedge clk); #1;
        mem_write = 1'b1; address = 32'd1064; wdata = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(negedge clk);
        chk("mid_high_we_n", 32'(sram_we_n), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_rdata", rdata, 32'd0);
        ref_half[20] = 16'hF00D;
        ref_half[21] = 16'hCAFE;
        last_rd = 32'd0;
        access(1'b1, 1'b0, 32'd1064, 32'd0, 1'b1);
        go_idle();
`endif

        // Random traffic against the reference memory.
        for (int t = 0; t < 40; t++) begin
            op = int'($urandom_range(0, 7));
            a  = BASE + 4 * $urandom_range(0, 127);
            access((op == 0) || (op >= 4), (op <= 3), a, $urandom, !POSTED);
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();

        // Store after idle, then load of it: store is released immediately when posted.
        access(1'b0, 1'b1, 32'd1100, 32'h13579BDF, 1'b1);
        access(1'b1, 1'b0, 32'd1100, 32'd0, !POSTED);
        chk("lit_post_raw", rdata, 32'h13579BDF);
        go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
